frame_scan_controller: RTL and testbench
========================================

Name: frame_scan_controller

Overview:
Sequences the camera pixel stream into the integral/line-buffer datapath of the face detection system. Accepts pixels from an upstream source via valid/ready, forwards one pixel per datapath request with its raster coordinates, and holds the frame boundary until classifier evaluation of the last windows completes. Reports frame and candidate statistics to the OS side. Sits between the camera/OS pixel source and the I2LBS/haar_database pair inside facial_detection_ip, and replaces that module's inline coordinate iteration.

Parameters:
FRAME_WIDTH, 100, pixels per line of the original camera frame
FRAME_HEIGHT, 24, lines per original frame
DATA_WIDTH, 12, pixel and coordinate width
INTEGRAL_LENGTH, 24, detection window side; gates window-ready
COUNT_WIDTH, 16, width of frame and candidate counters

Ports:
clk_os  in  1  pixel-domain clock
reset_fpga  in  1  asynchronous, active-high reset
i_enable  in  1  run request; level-sensitive
i_src_valid  in  1  upstream pixel valid
i_src_pixel  in  DATA_WIDTH  upstream pixel data
o_src_ready  out  1  upstream pixel accepted this cycle when high with i_src_valid
i_pixel_request  in  1  datapath (I2LBS) asks for next pixel
o_pixel  out  DATA_WIDTH  pixel to datapath
o_pixel_valid  out  1  one-cycle strobe, o_pixel/o_x/o_y valid
o_x  out  DATA_WIDTH  column of presented pixel
o_y  out  DATA_WIDTH  row of presented pixel
o_window_ready  out  1  presented pixel completes a full INTEGRAL_LENGTH window
i_eval_busy  in  1  classifier database walk in progress (database_request)
i_candidate  in  1  face candidate strobe from datapath
o_frame_start  out  1  pulse with first pixel (0,0) of a frame
o_frame_end  out  1  pulse when frame fully evaluated
o_frame_count  out  COUNT_WIDTH  completed frames, wraps
o_candidate_count  out  COUNT_WIDTH  candidates in current frame, saturating
o_starve  out  1  sticky: request seen with no source pixel
o_state  out  2  FSM state for debug

Behaviour:
- Reset (async, reset_fpga high): state IDLE; all outputs 0; internal x/y counters 0.
- States: IDLE=0, STREAM=1, DRAIN=2, DONE=3.
- IDLE -> STREAM when i_enable=1.
- STREAM: o_src_ready = i_pixel_request (combinational, only in STREAM). Transfer = i_pixel_request & i_src_valid.
- On transfer: next cycle o_pixel_valid=1, o_pixel=i_src_pixel, o_x/o_y = counters at transfer; counters advance raster order (x wraps at FRAME_WIDTH-1, then y increments). Latency 1 cycle request->valid.
- o_window_ready registered with o_pixel_valid: 1 iff x>=INTEGRAL_LENGTH-1 and y>=INTEGRAL_LENGTH-1; 0 when o_pixel_valid=0.
- o_frame_start = o_pixel_valid & (o_x==0) & (o_y==0).
- i_pixel_request=1 with i_src_valid=0 in STREAM: no transfer, o_starve set, cleared only by reset.
- Transfer of (FRAME_WIDTH-1, FRAME_HEIGHT-1): counters wrap to (0,0); STREAM -> DRAIN.
- DRAIN: o_src_ready=0. Exits the first cycle i_eval_busy=0 and o_pixel_valid=0 -> DONE.
- DONE: single cycle; o_frame_end=1 (registered, so asserted while in DONE); o_frame_count+1 mod 2^COUNT_WIDTH. DONE -> STREAM if i_enable=1, else IDLE.
- i_enable dropped mid-frame: frame runs to completion (no abort), then IDLE.
- o_candidate_count: +1 per cycle i_candidate=1, saturates at all-ones; cleared on the cycle o_frame_start asserts. Simultaneous clear and candidate gives 1. Candidates in DRAIN/DONE count toward the finishing frame.
- Reset mid-frame: immediate return to IDLE, counters 0; next frame restarts at (0,0).
- Coordinate compares use DATA_WIDTH unsigned; FRAME_WIDTH, FRAME_HEIGHT <= 2^DATA_WIDTH.

Decomposition:
- Shared package (face_detect_pkg): state encodings, DATA_WIDTH/COUNT_WIDTH defaults, frame dimension constants used by I2LBS and this block.
- One sub-module: raster_counter (x/y counters with wrap and last-pixel flag), reusable for resized-frame coordinates.

Test Plan:
- W=4,H=3,L=2; source always valid, request every cycle -> 12 valid strobes, coords (0,0)..(3,2) raster, frame_start on the first strobe, window_ready on the 6 strobes with x>=1 and y>=1.
- Same config, i_eval_busy held 5 cycles after last pixel -> state DRAIN 5 cycles, then o_frame_end 1 cycle, o_frame_count=1.
- Request while i_src_valid=0 -> no strobe, o_starve=1 and stays 1 after frame completes.
- i_enable low at pixel 5 -> remaining 7 pixels still accepted, frame_end pulses, state IDLE, o_src_ready=0.
- 3 candidate strobes in frame 1, candidate coincident with frame 2 start -> count 3 at frame_end, then 1.
- Assert reset_fpga at pixel 7 -> outputs 0 asynchronously; after re-enable first strobe is (0,0) with frame_start.

Source files
------------

// File: rtl/face_detect_pkg.sv
// Shared definitions for the face detection pixel path: default widths,
// frame geometry and the scan controller state encoding.
package face_detect_pkg;

  localparam int DATA_WIDTH_DEF      = 12;
  localparam int COUNT_WIDTH_DEF     = 16;
  localparam int FRAME_WIDTH_DEF     = 100;
  localparam int FRAME_HEIGHT_DEF    = 24;
  localparam int INTEGRAL_LENGTH_DEF = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } scan_state_e;

endpackage

// File: rtl/frame_scan_controller_raster_counter.sv
// Raster-order x/y coordinate counter with wrap and last-pixel flag.
// Reusable for any frame size, including resized frames.
module raster_counter #(
  parameter int WIDTH = 12,
  parameter int COLS  = 100,
  parameter int ROWS  = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             advance_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             last_o
);

  localparam logic [WIDTH-1:0] X_LAST = WIDTH'(COLS - 1);
  localparam logic [WIDTH-1:0] Y_LAST = WIDTH'(ROWS - 1);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (advance_i) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/frame_scan_controller.sv
// Feeds the camera pixel stream to the integral/line-buffer datapath one
// pixel per request, tagging raster coordinates and holding frame end until evaluation drains.
module frame_scan_controller
  import face_detect_pkg::*;
#(
  parameter int FRAME_WIDTH     = FRAME_WIDTH_DEF,
  parameter int FRAME_HEIGHT    = FRAME_HEIGHT_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int INTEGRAL_LENGTH = INTEGRAL_LENGTH_DEF,
  parameter int COUNT_WIDTH     = COUNT_WIDTH_DEF
) (
  input  logic                   clk_os,
  input  logic                   reset_fpga,
  input  logic                   i_enable,
  input  logic                   i_src_valid,
  input  logic [DATA_WIDTH-1:0]  i_src_pixel,
  output logic                   o_src_ready,
  input  logic                   i_pixel_request,
  output logic [DATA_WIDTH-1:0]  o_pixel,
  output logic                   o_pixel_valid,
  output logic [DATA_WIDTH-1:0]  o_x,
  output logic [DATA_WIDTH-1:0]  o_y,
  output logic                   o_window_ready,
  input  logic                   i_eval_busy,
  input  logic                   i_candidate,
  output logic                   o_frame_start,
  output logic                   o_frame_end,
  output logic [COUNT_WIDTH-1:0] o_frame_count,
  output logic [COUNT_WIDTH-1:0] o_candidate_count,
  output logic                   o_starve,
  output logic [1:0]             o_state
);

  localparam logic [DATA_WIDTH-1:0] WIN_MIN = DATA_WIDTH'(INTEGRAL_LENGTH - 1);

  scan_state_e            state_q;
  logic                   pixel_valid_q, window_ready_q, frame_end_q, starve_q;
  logic [DATA_WIDTH-1:0]  pixel_q, x_q, y_q;
  logic [COUNT_WIDTH-1:0] frame_count_q, cand_count_q;
  logic [DATA_WIDTH-1:0]  cnt_x, cnt_y;
  logic                   cnt_last, streaming, transfer, frame_start, window_d;

  // Handshake: a pixel moves when o_src_ready and i_src_valid are both high
  // on a rising clk_os; o_src_ready simply mirrors the request while streaming.
  assign streaming   = (state_q == ST_STREAM);
  assign o_src_ready = streaming & i_pixel_request;
  assign transfer    = o_src_ready & i_src_valid;
  assign window_d    = (cnt_x >= WIN_MIN) && (cnt_y >= WIN_MIN);
  assign frame_start = pixel_valid_q && (x_q == '0) && (y_q == '0);

  raster_counter #(
    .WIDTH (DATA_WIDTH),
    .COLS  (FRAME_WIDTH),
    .ROWS  (FRAME_HEIGHT)
  ) u_raster (
    .clk_i     (clk_os),
    .rst_i     (reset_fpga),
    .advance_i (transfer),
    .x_o       (cnt_x),
    .y_o       (cnt_y),
    .last_o    (cnt_last)
  );

  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) begin
      state_q       <= ST_IDLE;
      frame_end_q   <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_end_q <= 1'b0;
      case (state_q)
        ST_IDLE:   if (i_enable) state_q <= ST_STREAM;
        ST_STREAM: if (transfer && cnt_last) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          // The last pixel strobe must leave the output stage before evaluation can be trusted idle.
          if (!i_eval_busy && !pixel_valid_q) begin
            state_q       <= ST_DONE;
            frame_end_q   <= 1'b1;
            frame_count_q <= frame_count_q + 1'b1;
          end
        end
        ST_DONE:   state_q <= i_enable ? ST_STREAM : ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_os or posedge reset_fpga) begin
    if (reset_fpga) begin
      pixel_valid_q  <= 1'b0;
      window_ready_q <= 1'b0;
      pixel_q        <= '0;
      x_q            <= '0;
      y_q            <= '0;
      starve_q       <= 1'b0;
      cand_count_q   <= '0;
    end else begin
      pixel_valid_q  <= transfer;
      window_ready_q <= transfer & window_d;
      if (transfer) begin
        pixel_q <= i_src_pixel;
        x_q     <= cnt_x;
        y_q     <= cnt_y;
      end
      if (streaming && i_pixel_request && !i_src_valid) starve_q <= 1'b1;
      if (frame_start) begin
        cand_count_q <= {{(COUNT_WIDTH-1){1'b0}}, i_candidate};
      end else if (i_candidate && (cand_count_q != '1)) begin
        cand_count_q <= cand_count_q + 1'b1;
      end
    end
  end

  assign o_pixel           = pixel_q;
  assign o_pixel_valid     = pixel_valid_q;
  assign o_x               = x_q;
  assign o_y               = y_q;
  assign o_window_ready    = window_ready_q;
  assign o_frame_start     = frame_start;
  assign o_frame_end       = frame_end_q;
  assign o_frame_count     = frame_count_q;
  assign o_candidate_count = cand_count_q;
  assign o_starve          = starve_q;
  assign o_state           = state_q;

endmodule

// File: tb/tb_frame_scan_controller.sv
// Directed bench for frame_scan_controller on a 4x3 frame with a 2-pixel window.
module tb_frame_scan_controller;

  localparam int FW = 4;
  localparam int FH = 3;
  localparam int IL = 2;
  localparam int DW = 12;
  localparam int CW = 4;
  localparam int EW = 3 * DW + 1;

  logic          clk_os = 1'b0;
  logic          reset_fpga = 1'b1;
  logic          i_enable = 1'b0, i_src_valid = 1'b0, i_pixel_request = 1'b0;
  logic          i_eval_busy = 1'b0, i_candidate = 1'b0;
  logic [DW-1:0] i_src_pixel = '0;
  logic          o_src_ready, o_pixel_valid, o_window_ready;
  logic          o_frame_start, o_frame_end, o_starve;
  logic [DW-1:0] o_pixel, o_x, o_y;
  logic [CW-1:0] o_frame_count, o_candidate_count;
  logic [1:0]    o_state;

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  int  mx, my, pushed;
  logic pend;

  frame_scan_controller #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .DATA_WIDTH(DW),
    .INTEGRAL_LENGTH(IL), .COUNT_WIDTH(CW)
  ) dut (
    .clk_os(clk_os), .reset_fpga(reset_fpga), .i_enable(i_enable),
    .i_src_valid(i_src_valid), .i_src_pixel(i_src_pixel), .o_src_ready(o_src_ready),
    .i_pixel_request(i_pixel_request), .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid),
    .o_x(o_x), .o_y(o_y), .o_window_ready(o_window_ready), .i_eval_busy(i_eval_busy),
    .i_candidate(i_candidate), .o_frame_start(o_frame_start), .o_frame_end(o_frame_end),
    .o_frame_count(o_frame_count), .o_candidate_count(o_candidate_count),
    .o_starve(o_starve), .o_state(o_state)
  );

  // Clock and reset
  always #5 clk_os = ~clk_os;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    exp_q.delete();
    mx = 0; my = 0; pushed = 0; pend = 1'b0;
  endtask

  task automatic apply_reset();
    reset_fpga = 1'b1;
    i_enable = 0; i_src_valid = 0; i_src_pixel = '0; i_pixel_request = 0;
    i_eval_busy = 0; i_candidate = 0;
    repeat (2) @(posedge clk_os);
    #1 reset_fpga = 1'b0;
    model_clear();
  endtask

  // Driver: observes the handshake, records the expected strobe with the bench's own
  // raster coordinates, then advances one clock; returns at posedge+1.
  task automatic drive_cycle();
    #1;
    pend = o_src_ready & i_src_valid;
    if (pend) begin
      exp_q.push_back({i_src_pixel, DW'(mx), DW'(my), ((mx >= IL-1) && (my >= IL-1))});
      pushed++;
      if (mx == FW-1) begin
        mx = 0;
        my = (my == FH-1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    @(posedge clk_os);
    #1;
  endtask

  task automatic test_reset();
    reset_fpga = 1'b1;
    i_enable = 1; i_src_valid = 1; i_pixel_request = 1; i_candidate = 1;
    repeat (2) @(posedge clk_os);
    #1;
    checks++;
    if (o_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", o_state); end
    checks++;
    if ({o_src_ready, o_pixel_valid, o_window_ready, o_frame_start, o_frame_end, o_starve} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {o_src_ready, o_pixel_valid, o_window_ready, o_frame_start, o_frame_end, o_starve});
    end
    checks++;
    if ({o_pixel, o_x, o_y, o_frame_count, o_candidate_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: got pix=%0h x=%0d y=%0d fc=%0d cc=%0d expected all 0",
               o_pixel, o_x, o_y, o_frame_count, o_candidate_count);
    end
    apply_reset();
  endtask

  task automatic test_stream();
    int strobes = 0;
    int wins = 0;
    logic [EW-1:0] e;
    apply_reset();
    i_enable = 1; i_src_valid = 1; i_pixel_request = 1;
    for (int c = 0; c < 40 && pushed < FW*FH; c++) begin
      i_src_pixel = DW'(12'h100 + c * 7);
      drive_cycle();
      checks++;
      if (o_pixel_valid !== pend) begin
        errors++; $display("FAIL stream_valid: got %b expected %b (cycle %0d)", o_pixel_valid, pend, c);
      end
      if (pend && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        strobes++;
        if (o_window_ready) wins++;
        checks++;
        if ({o_pixel, o_x, o_y, o_window_ready} !== e) begin
          errors++;
          $display("FAIL stream_pixel: got pix=%0h x=%0d y=%0d win=%b expected pix=%0h x=%0d y=%0d win=%b",
                   o_pixel, o_x, o_y, o_window_ready, e[EW-1 -: DW], e[2*DW -: DW], e[DW -: DW], e[0]);
        end
        checks++;
        if (o_frame_start !== (strobes == 1)) begin
          errors++; $display("FAIL stream_frame_start: got %b on strobe %0d", o_frame_start, strobes);
        end
      end
    end
    checks++;
    if (strobes != 12 || wins != 6) begin
      errors++; $display("FAIL stream_counts: got strobes=%0d wins=%0d expected 12 and 6", strobes, wins);
    end
    checks++;
    if (o_state !== 2'd2 || o_src_ready !== 1'b0) begin
      errors++; $display("FAIL stream_drain_entry: got state=%0d ready=%b expected 2 and 0", o_state, o_src_ready);
    end
    @(posedge clk_os); #1;
    checks++;
    if (o_state !== 2'd2 || o_pixel_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain_hold: got state=%0d valid=%b expected 2 and 0", o_state, o_pixel_valid);
    end
    @(posedge clk_os); #1;
    checks++;
    if (o_state !== 2'd3 || o_frame_end !== 1'b1 || o_frame_count !== 4'd1) begin
      errors++;
      $display("FAIL stream_done: got state=%0d end=%b fc=%0d expected 3 1 1", o_state, o_frame_end, o_frame_count);
    end
    i_pixel_request = 0;
    @(posedge clk_os); #1;
    checks++;
    if (o_state !== 2'd1 || o_frame_end !== 1'b0) begin
      errors++; $display("FAIL stream_restart: got state=%0d end=%b expected 1 and 0", o_state, o_frame_end);
    end
  endtask

  // Continues from test_stream: second frame, evaluation busy from the last transfer for 5 cycles.
  task automatic test_drain();
    int busy_left = 0;
    int drain = 0;
    int strobes = 0;
    model_clear();
    i_pixel_request = 1;
    for (int c = 0; c < 40 && pushed < FW*FH; c++) begin
      if (pushed == FW*FH - 1) busy_left = 5;
      i_eval_busy = (busy_left > 0);
      drive_cycle();
      if (busy_left > 0) busy_left--;
      if (o_pixel_valid) strobes++;
    end
    for (int c = 0; c < 20 && o_state == 2'd2; c++) begin
      drain++;
      checks++;
      if (o_frame_end !== 1'b0 || o_src_ready !== 1'b0) begin
        errors++; $display("FAIL drain_outputs: got end=%b ready=%b expected 0 0", o_frame_end, o_src_ready);
      end
      i_eval_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      @(posedge clk_os); #1;
    end
    checks++;
    if (drain != 5 || strobes != 12) begin
      errors++; $display("FAIL drain_length: got drain=%0d strobes=%0d expected 5 and 12", drain, strobes);
    end
    checks++;
    if (o_state !== 2'd3 || o_frame_end !== 1'b1 || o_frame_count !== 4'd2) begin
      errors++;
      $display("FAIL drain_done: got state=%0d end=%b fc=%0d expected 3 1 2", o_state, o_frame_end, o_frame_count);
    end
    i_pixel_request = 0;
    @(posedge clk_os); #1;
    checks++;
    if (o_frame_end !== 1'b0) begin errors++; $display("FAIL drain_end_pulse: got %b expected 0", o_frame_end); end
  endtask

  task automatic test_starve();
    int strobes = 0;
    apply_reset();
    i_pixel_request = 1; i_src_valid = 0;
    repeat (2) drive_cycle();
    checks++;
    if (o_starve !== 1'b0) begin errors++; $display("FAIL starve_idle: got %b expected 0", o_starve); end
    i_enable = 1;
    for (int c = 0; c < 4; c++) begin
      drive_cycle();
      if (o_pixel_valid) strobes++;
    end
    checks++;
    if (o_starve !== 1'b1 || strobes != 0 || o_src_ready !== 1'b1) begin
      errors++;
      $display("FAIL starve_set: got starve=%b strobes=%0d ready=%b expected 1 0 1", o_starve, strobes, o_src_ready);
    end
    i_src_valid = 1;
    for (int c = 0; c < 40 && pushed < FW*FH; c++) begin
      drive_cycle();
      if (o_pixel_valid) strobes++;
    end
    i_pixel_request = 0;
    for (int c = 0; c < 10 && o_state != 2'd3; c++) begin
      @(posedge clk_os); #1;
    end
    @(posedge clk_os); #1;
    checks++;
    if (o_starve !== 1'b1 || strobes != 12 || o_frame_count !== 4'd1) begin
      errors++;
      $display("FAIL starve_sticky: got starve=%b strobes=%0d fc=%0d expected 1 12 1", o_starve, strobes, o_frame_count);
    end
  endtask

  task automatic test_enable_drop();
    int strobes = 0;
    apply_reset();
    i_enable = 1; i_src_valid = 1; i_pixel_request = 1;
    for (int c = 0; c < 40 && pushed < FW*FH; c++) begin
      if (pushed == 5) i_enable = 0;
      drive_cycle();
      if (o_pixel_valid) strobes++;
    end
    checks++;
    if (strobes != 12) begin errors++; $display("FAIL enable_drop_pixels: got %0d expected 12", strobes); end
    for (int c = 0; c < 10 && o_state != 2'd3; c++) begin
      @(posedge clk_os); #1;
    end
    checks++;
    if (o_frame_end !== 1'b1 || o_frame_count !== 4'd1) begin
      errors++; $display("FAIL enable_drop_end: got end=%b fc=%0d expected 1 1", o_frame_end, o_frame_count);
    end
    repeat (2) @(posedge clk_os);
    #1;
    checks++;
    if (o_state !== 2'd0 || o_src_ready !== 1'b0 || o_pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop_idle: got state=%0d ready=%b valid=%b expected 0 0 0", o_state, o_src_ready, o_pixel_valid);
    end
  endtask

  task automatic test_candidates();
    int strobes = 0;
    logic cand_next = 1'b0;
    apply_reset();
    i_enable = 1; i_src_valid = 1; i_pixel_request = 1;
    for (int c = 0; c < 40 && pushed < FW*FH; c++) begin
      i_candidate = (pushed == 3) || (pushed == 8);
      drive_cycle();
    end
    i_candidate = 1;
    @(posedge clk_os); #1;
    i_candidate = 0;
    for (int c = 0; c < 10 && o_state != 2'd3; c++) begin
      @(posedge clk_os); #1;
    end
    checks++;
    if (o_frame_end !== 1'b1 || o_candidate_count !== 4'd3) begin
      errors++; $display("FAIL cand_frame1: got end=%b count=%0d expected 1 3", o_frame_end, o_candidate_count);
    end
    model_clear();
    for (int c = 0; c < 40 && pushed < FW*FH; c++) begin
      i_candidate = cand_next;
      cand_next = 1'b0;
      drive_cycle();
      if (o_pixel_valid) begin
        strobes++;
        if (strobes == 1) begin
          cand_next = 1'b1;
          checks++;
          if (o_frame_start !== 1'b1 || o_candidate_count !== 4'd3) begin
            errors++;
            $display("FAIL cand_f2_start: got start=%b count=%0d expected 1 3", o_frame_start, o_candidate_count);
          end
        end
        if (strobes == 2) begin
          checks++;
          if (o_candidate_count !== 4'd1) begin
            errors++; $display("FAIL cand_clear_and_count: got %0d expected 1", o_candidate_count);
          end
        end
      end
    end
    i_candidate = 1; i_eval_busy = 1;
    repeat (16) @(posedge clk_os);
    #1;
    checks++;
    if (o_candidate_count !== 4'hF || o_state !== 2'd2) begin
      errors++; $display("FAIL cand_saturate: got count=%0d state=%0d expected 15 2", o_candidate_count, o_state);
    end
    @(posedge clk_os); #1;
    checks++;
    if (o_candidate_count !== 4'hF) begin errors++; $display("FAIL cand_hold: got %0d expected 15", o_candidate_count); end
    i_candidate = 0; i_eval_busy = 0;
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] e;
    int found = 0;
    apply_reset();
    i_enable = 1; i_src_valid = 1; i_pixel_request = 1;
    for (int c = 0; c < 40 && pushed < 7; c++) begin
      i_src_pixel = DW'(12'h200 + c);
      drive_cycle();
    end
    #2 reset_fpga = 1'b1;
    #1;
    checks++;
    if (o_state !== 2'd0 || o_pixel_valid !== 1'b0 || o_x !== '0 || o_y !== '0 || o_pixel !== '0) begin
      errors++;
      $display("FAIL reset_mid_async: got state=%0d valid=%b x=%0d y=%0d pix=%0h expected all 0",
               o_state, o_pixel_valid, o_x, o_y, o_pixel);
    end
    @(posedge clk_os);
    #1 reset_fpga = 1'b0;
    model_clear();
    i_src_pixel = 12'h3A5;
    for (int c = 0; c < 10 && found == 0; c++) begin
      drive_cycle();
      if (o_pixel_valid) begin
        found = 1;
        e = exp_q.pop_front();
        checks++;
        if (o_x !== '0 || o_y !== '0 || o_frame_start !== 1'b1 || o_pixel !== e[EW-1 -: DW]) begin
          errors++;
          $display("FAIL reset_mid_restart: got x=%0d y=%0d start=%b pix=%0h expected 0 0 1 %0h",
                   o_x, o_y, o_frame_start, o_pixel, e[EW-1 -: DW]);
        end
      end
    end
    checks++;
    if (found == 0) begin errors++; $display("FAIL reset_mid_timeout: got no strobe expected one"); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_drain();
    test_starve();
    test_enable_drop();
    test_candidates();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
